// File: rtl/pwm_cmd_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_cmd_parser: ASCII UART command parser holding PWM configuration regs |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pwm_cmd_parser #(
   parameter int TIMEOUT_CYCLES = 50000000,
   parameter int DUTY_MAX       = 100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [1:0] pow2_cfg,
   output logic [1:0] pow5_cfg,
   output logic [6:0] duty_cfg,
   output logic       cfg_valid,
   output logic       busy
);

   localparam int         TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] DUTY_LIM = 8'(DUTY_MAX);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_NUM  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [1:0] CMD_D = 2'd0;
   localparam logic [1:0] CMD_P = 2'd1;
   localparam logic [1:0] CMD_F = 2'd2;

   localparam logic [7:0] CH_K = 8'h4B;
   localparam logic [7:0] CH_E = 8'h45;

   logic [1:0]    state, state_nx;
   logic [1:0]    cmd, cmd_nx;
   logic [7:0]    acc, acc_nx;
   logic [1:0]    cnt, cnt_nx;
   logic [TW-1:0] tmo, tmo_nx;
   logic [7:0]    tx_data_nx;
   logic [1:0]    pow2_nx, pow5_nx;
   logic [6:0]    duty_nx;
   logic          cfg_valid_nx;

   logic          is_digit, is_eol, is_letter, in_range;
   logic [1:0]    letter_cmd;
   logic [11:0]   acc_ext;
   logic [7:0]    acc_sat;

   assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
   assign is_eol   = (rx_data == 8'h0D) || (rx_data == 8'h0A);

   always_comb begin
      is_letter  = 1'b1;
      letter_cmd = CMD_D;
      case (rx_data)
         8'h44, 8'h64: letter_cmd = CMD_D;
         8'h50, 8'h70: letter_cmd = CMD_P;
         8'h46, 8'h66: letter_cmd = CMD_F;
         default:      is_letter  = 1'b0;
      endcase
   end

   // Saturate so that oversized numbers like 999 fail the range check instead of wrapping
   assign acc_ext = 12'(acc) * 12'd10 + 12'(rx_data[3:0]);
   assign acc_sat = (acc_ext > 12'd255) ? 8'd255 : acc_ext[7:0];

   always_comb begin
      case (cmd)
         CMD_D:   in_range = (acc <= DUTY_LIM);
         default: in_range = (acc <= 8'd3);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cmd       <= CMD_D;
         acc       <= '0;
         cnt       <= '0;
         tmo       <= '0;
         tx_data   <= '0;
         pow2_cfg  <= '0;
         pow5_cfg  <= '0;
         duty_cfg  <= '0;
         cfg_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         cmd       <= cmd_nx;
         acc       <= acc_nx;
         cnt       <= cnt_nx;
         tmo       <= tmo_nx;
         tx_data   <= tx_data_nx;
         pow2_cfg  <= pow2_nx;
         pow5_cfg  <= pow5_nx;
         duty_cfg  <= duty_nx;
         cfg_valid <= cfg_valid_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      cmd_nx       = cmd;
      acc_nx       = acc;
      cnt_nx       = cnt;
      tmo_nx       = tmo;
      tx_data_nx   = tx_data;
      pow2_nx      = pow2_cfg;
      pow5_nx      = pow5_cfg;
      duty_nx      = duty_cfg;
      cfg_valid_nx = 1'b0;
      case (state)
         S_IDLE: begin
            if (rx_valid) begin
               if (is_letter) begin
                  cmd_nx   = letter_cmd;
                  acc_nx   = '0;
                  cnt_nx   = '0;
                  tmo_nx   = '0;
                  state_nx = S_NUM;
               end else if (!is_eol) begin
                  tx_data_nx = CH_E;
                  state_nx   = S_RESP;
               end
            end
         end
         S_NUM: begin
            if (rx_valid) begin
               tmo_nx = '0;
               if (is_digit) begin
                  if (cnt == 2'd3) begin
                     tx_data_nx = CH_E;
                     state_nx   = S_RESP;
                  end else begin
                     acc_nx = acc_sat;
                     cnt_nx = cnt + 2'd1;
                  end
               end else if (is_eol) begin
                  state_nx = S_RESP;
                  if ((cnt == 2'd0) || !in_range) begin
                     tx_data_nx = CH_E;
                  end else begin
                     tx_data_nx   = CH_K;
                     cfg_valid_nx = 1'b1;
                     case (cmd)
                        CMD_P:   pow2_nx = acc[1:0];
                        CMD_F:   pow5_nx = acc[1:0];
                        default: duty_nx = acc[6:0];
                     endcase
                  end
               end else begin
                  tx_data_nx = CH_E;
                  state_nx   = S_RESP;
               end
            end else if (tmo == TMO_LAST) begin
               tmo_nx     = '0;
               tx_data_nx = CH_E;
               state_nx   = S_RESP;
            end else begin
               tmo_nx = tmo + 1'b1;
            end
         end
         S_RESP: begin
            if (tx_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != S_IDLE);
      tx_valid = (state == S_RESP);
   end

endmodule
`default_nettype wire

// File: doc/pwm_cmd_parser.md
Name: pwm_cmd_parser

Overview:
- Sits between the UART receiver/transmitter and pwm_ctrl.
- Parses ASCII commands from the UART RX byte stream and holds the PWM configuration registers (pow2_cfg, pow5_cfg, duty_cfg).
- Pulses cfg_valid to pwm_ctrl on each accepted command.
- Returns a one-byte acknowledge ('K') or error ('E') to the UART TX through a valid/ready handshake.

Parameters:
- TIMEOUT_CYCLES, 50000000: idle cycles allowed between bytes inside a command before abort (1 s at 50 MHz).
- DUTY_MAX, 100: largest accepted duty value.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- rx_data  input  8  received byte from UART RX.
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
- tx_data  output  8  response byte to UART TX.
- tx_valid  output  1  response available; held until tx_ready.
- tx_ready  input  1  UART TX accepts tx_data this cycle when tx_valid=1.
- pow2_cfg  output  2  registered PWM pow2 setting.
- pow5_cfg  output  2  registered PWM pow5 setting.
- duty_cfg  output  7  registered PWM duty setting, percent.
- cfg_valid  output  1  one-cycle pulse; all three cfg outputs are valid and updated.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low; all state and outputs are cleared immediately on rst_n=0.
- Reset values: pow2_cfg=0, pow5_cfg=0, duty_cfg=0, cfg_valid=0, tx_valid=0, tx_data=0x00, busy=0, state=IDLE, accumulator=0, digit count=0, timeout counter=0.
- Command grammar: <letter><1-3 decimal digits><CR or LF>.
  - 'D'/'d' sets duty, range 0..DUTY_MAX.
  - 'P'/'p' sets pow2, range 0..3.
  - 'F'/'f' sets pow5, range 0..3.
- IDLE state, on rx_valid:
  - Valid letter: latch command type, clear acc (8-bit) and digit count, go to NUM.
  - CR (0x0D) or LF (0x0A): ignored, stay in IDLE.
  - Any other byte: tx_data='E', go to RESP.
- NUM state, on rx_valid:
  - Digit '0'..'9':
    - If digit count < 3: acc = acc*10 + digit, saturating at 255; count++.
    - If digit count = 3 (fourth digit): 'E', go to RESP.
  - CR or LF:
    - If count = 0 or value is out of range: 'E'.
    - Otherwise: write the target register, pulse cfg_valid, respond 'K'.
    - Either way, go to RESP.
  - Any other byte: 'E', go to RESP.
- Timeout in NUM:
  - Counter increments each cycle without rx_valid and clears on rx_valid.
  - When it reaches TIMEOUT_CYCLES-1: 'E', go to RESP.
  - No register change.
- Latency: register update, cfg_valid=1, tx_valid=1 and tx_data all take effect on the clock edge that samples the terminator byte. cfg_valid is high for exactly one cycle. Registers not addressed by the command keep their values.
- RESP state:
  - tx_valid=1, and tx_data is held stable until the cycle where tx_valid&&tx_ready.
  - On that edge: tx_valid drops and the block returns to IDLE.
  - tx_ready asserted in the first RESP cycle gives a single-cycle response.
- Backpressure: rx_valid bytes arriving in RESP are dropped with no effect. The UART RX has no backpressure, so the host must wait for the response byte.
- Simultaneous events:
  - Timeout expiry and rx_valid in the same cycle: rx_valid wins and the timeout counter clears.
  - Reset mid-command or mid-RESP: aborts immediately, emits no response, and returns registers to 0.
- Arithmetic: the saturating accumulator guarantees "999" is rejected rather than wrapping. duty_cfg takes acc[6:0] only after the range check passes.

Test Plan:
1. Reset, then send "D25\r" → one cfg_valid pulse with duty_cfg=25, pow2_cfg=0, pow5_cfg=0; tx_data='K' (0x4B) with tx_valid held until tx_ready.
2. Send "P2\n" then "f3\r" → two cfg_valid pulses; pow2_cfg=2, then pow5_cfg=3; duty_cfg unchanged at 25; two 'K' responses.
3. Send "D101\r", "D1234\r", "P4\r", "D\r", "X" → each yields 'E' (0x45), no cfg_valid, registers unchanged. For "D1234\r", the bytes after the fourth digit arrive during or after RESP; the CR is ignored in IDLE.
4. Send "D5", then idle TIMEOUT_CYCLES (bench overrides to 100) → 'E' after exactly 100 idle cycles; duty unchanged. A following "D50\r" succeeds.
5. Send "D75\r" with tx_ready held low for 20 cycles → tx_valid and tx_data='K' stay stable for 20 cycles; busy=1 throughout; a "D10\r" injected during RESP is dropped; duty_cfg=75.
6. Assert rst_n=0 asynchronously in the middle of "D4" → all outputs read 0 before the next clk edge; after release, "D33\r" yields duty_cfg=33 and 'K'.
